handshaking_master_burst: RTL and testbench
===========================================

Name: handshaking_master_burst

Overview:
Parametrised successor to the single-word handshaking master. It accepts words from a local producer over a valid/ready interface and buffers them in a DEPTH-entry FIFO. It emits them to a downstream slave over the same data_valid/data_ready handshake, either word-by-word or in fixed-length bursts. It also flags a stalled slave via a sticky timeout.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 4, FIFO entries; power of two, >=2
BURST_LEN, 1, words per burst; 1 = streaming; 1 <= BURST_LEN <= DEPTH
TIMEOUT, 255, consecutive stalled cycles before stall_timeout sets; >=1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
data_in  input  DATA_WIDTH  producer word
in_valid  input  1  producer word valid
in_ready  output  1  buffer can accept (= !full)
data_out  output  DATA_WIDTH  word to slave
data_valid  output  1  data_out valid
data_ready  input  1  slave accepts
flush  input  1  single-cycle pulse: release a partial burst
clear  input  1  clears stall_timeout
count  output  $clog2(DEPTH+1)  words held
full  output  1  count == DEPTH
empty  output  1  count == 0
stall_timeout  output  1  sticky stall flag

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset (async, immediate): pointers=0, count=0, state=FILL, beat counter=0, stall counter=0, stall_timeout=0. Outputs: data_valid=0, in_ready=1, empty=1, full=0. data_out is don't-care while data_valid=0.
- Write: when in_valid && in_ready, data_in is stored at wr_ptr on the edge. in_ready is combinational !full.
- Read: when data_valid && data_ready, the head word is popped on the edge.
- data_out = mem[rd_ptr], combinational from registers. A word written at edge k is presentable after edge k, giving one-cycle fill latency.
- Pointers wrap modulo DEPTH. count is +1 on write only, -1 on read only, and unchanged on both or neither.
- Full: in_ready=0 and no write, even if a read occurs in the same cycle.
- Empty: data_valid=0 and no read.
- State machine:
  FILL: data_valid=0. Go to DRAIN with beats=BURST_LEN when count >= BURST_LEN. Else go to DRAIN with beats=count when flush && count>0. flush with count==0 is ignored.
  DRAIN: data_valid=1. Each read decrements beats. The read with beats==1 returns to FILL.
- The comparison uses registered count, so an entry into DRAIN appears the cycle after the threshold is reached.
- With BURST_LEN=1 and count>0, FILL→DRAIN→FILL repeats, giving at most one word per 2 cycles. Full-rate streaming is therefore not required for BURST_LEN=1.
- Handshake rules:
  - data_valid, once high, stays high and data_out stays stable until accepted. This holds because the burst words are resident at DRAIN entry.
  - data_valid never depends combinationally on data_ready.
  - flush during DRAIN is ignored.
- Stall counter:
  - Increments each cycle with data_valid && !data_ready.
  - Clears on any read or in FILL.
  - Saturates at TIMEOUT. On reaching TIMEOUT, stall_timeout sets.
  - stall_timeout holds until clear or rst. clear and a new timeout in the same cycle: set wins.
- Reset mid-burst: buffered data is discarded and all state returns to reset values.

Decomposition:
- Shared package: state encoding (FILL, DRAIN) and the width helper for count/pointer widths ($clog2).
- One natural sub-module: handshaking_fifo_core, covering the storage array, pointers, count, full and empty. The top adds the burst FSM, beat counter and stall logic.

Test Plan:
Shared configuration: DATA_WIDTH=8, DEPTH=4. rst is asserted mid-cycle in test 1.
1. Reset: assert rst asynchronously between edges → data_valid=0, in_ready=1, count=0, stall_timeout=0 without waiting for a clock edge.
2. Streaming (BURST_LEN=1): write 0x96 then 0x69, data_ready=1 → data_out shows 0x96 then 0x69 in order. Each word is accepted exactly once and count returns to 0.
3. Full (BURST_LEN=1): hold data_ready=0 and write 0x01..0x05 → the first word enters DRAIN and is held valid. 0x01..0x04 are accepted, count=4, full=1, in_ready=0, and 0x05 is not accepted. Then pulse data_ready for 4 accepts → 0x01..0x04 come out in order.
4. Burst (BURST_LEN=2): write 0xA1, then wait → data_valid stays 0. Write 0xA2 → data_valid rises the cycle after count=2, and exactly 2 words leave before returning to FILL.
5. Flush (BURST_LEN=2): write 0xB1 then pulse flush → 0xB1 is emitted alone. A flush while count=0 produces no data_valid.
6. Timeout (TIMEOUT=4): one word buffered, data_ready=0 → stall_timeout=1 after 4 stalled cycles and stays 1 after the word is accepted. Pulse clear → 0.

Source files
------------

// File: rtl/handshaking_master_burst_pkg.sv
// Shared types and sizing helpers for the burst handshaking master and its FIFO core.
package handshaking_master_burst_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Bit width needed to index/count n values; never returns less than 1.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshaking_fifo_core.sv
// DEPTH-entry circular buffer with occupancy count; guards its own overflow/underflow.
module handshaking_fifo_core
    import handshaking_master_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_wr_en,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    input  logic                              i_rd_en,
    output logic [DATA_WIDTH-1:0]             o_rd_data,
    output logic [width_of(DEPTH+1)-1:0]      o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int unsigned PW = width_of(DEPTH);
    localparam int unsigned CW = width_of(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset: contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/handshaking_master_burst.sv
// Buffered handshaking master: emits FIFO words in fixed-length or flushed bursts, with sticky stall timeout.
module handshaking_master_burst
    import handshaking_master_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BURST_LEN  = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             i_data_in,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    input  logic                              i_flush,
    input  logic                              i_clear,
    output logic [width_of(DEPTH+1)-1:0]      o_count,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_stall_timeout
);

    localparam int unsigned CW = width_of(DEPTH + 1);
    localparam int unsigned SW = width_of(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_beats;
    logic [CW-1:0] w_beats_nxt;
    logic [SW-1:0] r_stall_cnt;
    logic [SW-1:0] w_stall_nxt;
    logic          r_stall_timeout;
    logic          w_stall_set;
    logic          w_data_valid;
    logic          w_rd;
    logic          w_full;
    logic [CW-1:0] w_count;

    handshaking_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_in_valid),
        .i_wr_data (i_data_in),
        .i_rd_en   (w_rd),
        .o_rd_data (o_data_out),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (o_empty)
    );

    assign w_rd            = w_data_valid && i_data_ready;
    assign o_data_valid    = w_data_valid;
    assign o_in_ready      = !w_full;
    assign o_full          = w_full;
    assign o_count         = w_count;
    assign o_stall_timeout = r_stall_timeout;

    // Burst FSM: a burst only starts once all of its words are resident.
    always_comb begin
        w_state_nxt  = r_state;
        w_beats_nxt  = r_beats;
        w_data_valid = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_count >= CW'(BURST_LEN)) begin
                    w_state_nxt = ST_DRAIN;
                    w_beats_nxt = CW'(BURST_LEN);
                end else if (i_flush && (w_count != '0)) begin
                    w_state_nxt = ST_DRAIN;
                    w_beats_nxt = w_count;
                end
            end
            ST_DRAIN: begin
                w_data_valid = 1'b1;
                if (w_rd) begin
                    w_beats_nxt = r_beats - CW'(1);
                    if (r_beats == CW'(1)) begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_beats_nxt = '0;
            end
        endcase
    end

    // Stall counter saturates at TIMEOUT; reaching it sets the sticky flag.
    always_comb begin
        w_stall_nxt = '0;
        w_stall_set = 1'b0;
        if (w_data_valid && !i_data_ready) begin
            w_stall_nxt = (r_stall_cnt == SW'(TIMEOUT)) ? r_stall_cnt : r_stall_cnt + SW'(1);
            w_stall_set = (w_stall_nxt == SW'(TIMEOUT));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_FILL;
            r_beats         <= '0;
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beats     <= w_beats_nxt;
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_set) begin
                r_stall_timeout <= 1'b1;
            end else if (i_clear) begin
                r_stall_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_handshaking_master_burst.sv
// Directed and random checks of two burst-master instances (streaming and BURST_LEN=2) against a queue model.
module tb_handshaking_master_burst;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 4;
    localparam int unsigned CW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] din  [2];
    logic          iv   [2];
    logic          dr   [2];
    logic          fl   [2];
    logic          clr  [2];
    logic          irdy [2];
    logic          dv   [2];
    logic          full [2];
    logic          empt [2];
    logic          sto  [2];
    logic [DW-1:0] dout [2];
    logic [CW-1:0] cnt  [2];

    handshaking_master_burst #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(1), .TIMEOUT(TO)
    ) u_stream (
        .clk(clk), .rst(rst), .i_data_in(din[0]), .i_in_valid(iv[0]), .o_in_ready(irdy[0]),
        .o_data_out(dout[0]), .o_data_valid(dv[0]), .i_data_ready(dr[0]), .i_flush(fl[0]),
        .i_clear(clr[0]), .o_count(cnt[0]), .o_full(full[0]), .o_empty(empt[0]),
        .o_stall_timeout(sto[0])
    );

    handshaking_master_burst #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(2), .TIMEOUT(TO)
    ) u_burst (
        .clk(clk), .rst(rst), .i_data_in(din[1]), .i_in_valid(iv[1]), .o_in_ready(irdy[1]),
        .o_data_out(dout[1]), .o_data_valid(dv[1]), .i_data_ready(dr[1]), .i_flush(fl[1]),
        .i_clear(clr[1]), .o_count(cnt[1]), .o_full(full[1]), .o_empty(empt[1]),
        .o_stall_timeout(sto[1])
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: an ordered list of held words, words left in the current burst (0 = not emitting),
    // consecutive stalled cycles, and the sticky flag.
    logic [DW-1:0] m_data  [2][DEPTH];
    int            m_n     [2];
    int            m_left  [2];
    int            m_stall [2];
    bit            m_sto   [2];
    int            m_bl    [2];

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, i, obs, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]     = 0;
            m_left[i]  = 0;
            m_stall[i] = 0;
            m_sto[i]   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk("data_valid", i, 32'(dv[i]), 32'(m_left[i] > 0));
            chk("in_ready", i, 32'(irdy[i]), 32'(m_n[i] < DEPTH));
            chk("count", i, 32'(cnt[i]), 32'(m_n[i]));
            chk("full", i, 32'(full[i]), 32'(m_n[i] == DEPTH));
            chk("empty", i, 32'(empt[i]), 32'(m_n[i] == 0));
            chk("stall_timeout", i, 32'(sto[i]), 32'(m_sto[i]));
            if (m_left[i] > 0) begin
                chk("data_out", i, 32'(dout[i]), 32'(m_data[i][0]));
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit emitting;
            bit rd;
            bit wr;
            int nstall;
            emitting = (m_left[i] > 0);
            rd       = emitting && dr[i];
            wr       = iv[i] && (m_n[i] < DEPTH);
            nstall   = 0;
            if (emitting && !dr[i]) begin
                nstall = (m_stall[i] + 1 > TO) ? TO : m_stall[i] + 1;
            end
            if (emitting && !dr[i] && nstall == TO) begin
                m_sto[i] = 1'b1;
            end else if (clr[i]) begin
                m_sto[i] = 1'b0;
            end
            m_stall[i] = nstall;
            if (!emitting) begin
                if (m_n[i] >= m_bl[i]) begin
                    m_left[i] = m_bl[i];
                end else if (fl[i] && m_n[i] > 0) begin
                    m_left[i] = m_n[i];
                end
            end else if (rd) begin
                m_left[i] = m_left[i] - 1;
            end
            if (rd) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    m_data[i][k] = m_data[i][k+1];
                end
                m_n[i] = m_n[i] - 1;
            end
            if (wr) begin
                m_data[i][m_n[i]] = din[i];
                m_n[i] = m_n[i] + 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            iv[i]  = 1'b0;
            dr[i]  = 1'b0;
            fl[i]  = 1'b0;
            clr[i] = 1'b0;
        end
    endtask

    initial begin
        m_bl[0] = 1;
        m_bl[1] = 2;
        rst = 1'b1;
        idle_inputs();
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Streaming: 0x96 then 0x69 leave in order, one word per two cycles.
        dr[0] = 1'b1;
        iv[0] = 1'b1; din[0] = 8'h96; cycle();
        din[0] = 8'h69; cycle();
        iv[0] = 1'b0;
        repeat (5) cycle();

        // Full: 0x01..0x05 against a blocked slave; 0x05 must be refused.
        dr[0] = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            iv[0] = 1'b1; din[0] = 8'(v); cycle();
        end
        iv[0] = 1'b0;
        cycle();
        dr[0] = 1'b1;
        repeat (12) cycle();
        dr[0] = 1'b0;
        clr[0] = 1'b1; cycle();
        clr[0] = 1'b0; cycle();

        // Burst of two: a single word waits, the second releases both.
        dr[1] = 1'b1;
        iv[1] = 1'b1; din[1] = 8'hA1; cycle();
        iv[1] = 1'b0;
        repeat (3) cycle();
        iv[1] = 1'b1; din[1] = 8'hA2; cycle();
        iv[1] = 1'b0;
        repeat (5) cycle();

        // Flush releases a lone word; flush on an empty buffer does nothing.
        iv[1] = 1'b1; din[1] = 8'hB1; cycle();
        iv[1] = 1'b0;
        cycle();
        fl[1] = 1'b1; cycle();
        fl[1] = 1'b0;
        repeat (3) cycle();
        fl[1] = 1'b1; cycle();
        fl[1] = 1'b0;
        repeat (2) cycle();

        // Timeout: one word held against a blocked slave, flag sticks until clear.
        dr[0] = 1'b0;
        iv[0] = 1'b1; din[0] = 8'h5A; cycle();
        iv[0] = 1'b0;
        repeat (7) cycle();
        dr[0] = 1'b1;
        repeat (3) cycle();
        clr[0] = 1'b1; cycle();
        clr[0] = 1'b0; cycle();

        // Asynchronous reset between edges with data buffered in both instances.
        dr[0] = 1'b0; dr[1] = 1'b0;
        iv[0] = 1'b1; iv[1] = 1'b1; din[0] = 8'h33; din[1] = 8'h44;
        repeat (3) cycle();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Random traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                iv[i]  = ($urandom_range(0, 9) < 7);
                din[i] = 8'($urandom);
                dr[i]  = (c % 100 < 70) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 1);
                fl[i]  = ($urandom_range(0, 9) == 0);
                clr[i] = ($urandom_range(0, 19) == 0);
            end
            cycle();
        end
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
